// File: rtl/async_trigger_arbiter.sv
// Round-robin arbiter for asynchronous trigger requests: per-line synchronizer and
// rising-edge capture into pending flags, one-at-a-time grant handshake with hold-off.
module async_trigger_arbiter #(
    parameter  int N_REQ       = 4,
    parameter  int SYNC_STAGES = 3,
    parameter  int HOLDOFF_W   = 8,
    localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_REQ-1:0]     ASYNC_REQ,
    input  logic                 ENABLE,
    input  logic [HOLDOFF_W-1:0] HOLDOFF,
    input  logic                 TRIG_ACK,
    output logic                 TRIG_VALID,
    output logic [ID_W-1:0]      TRIG_ID,
    output logic [N_REQ-1:0]     PENDING,
    output logic [15:0]          DROP_COUNT,
    input  logic                 CLR_DROP
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD
    } state_t;

    state_t                 state;
    logic [HOLDOFF_W-1:0]   cnt;
    logic [ID_W-1:0]        last_grant;

    logic [N_REQ-1:0]       sync_out;
    logic [N_REQ-1:0]       history;
    logic [N_REQ-1:0]       req_edge;

    logic [ID_W-1:0]        winner;
    logic [ID_W-1:0]        idx;
    logic                   any_pend;
    logic                   grant_now;
    logic [N_REQ-1:0]       grant_clr;

    logic [N_REQ-1:0]       pend_next;
    logic [N_REQ-1:0]       drop_vec;
    logic [4:0]             n_drops;
    logic [16:0]            drop_sum;
    logic [15:0]            drop_next;

    // Each request line gets its own metastability chain; placement tools must keep
    // these flops together and never fold them into a shift-register primitive.
    for (genvar g = 0; g < N_REQ; g++) begin : g_sync
        (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic [SYNC_STAGES-1:0] sync_ff;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                sync_ff <= '0;
            end else begin
                sync_ff <= {sync_ff[SYNC_STAGES-2:0], ASYNC_REQ[g]};
            end
        end

        assign sync_out[g] = sync_ff[SYNC_STAGES-1];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            history <= '0;
        end else begin
            history <= sync_out;
        end
    end

    assign req_edge = sync_out & ~history;

    // Search starts just after the last winner and wraps, so the first hit wins.
    always_comb begin
        winner   = '0;
        idx      = '0;
        any_pend = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % N_REQ);
            if (!any_pend && PENDING[idx]) begin
                winner   = idx;
                any_pend = 1'b1;
            end
        end
    end

    assign grant_now = (state == IDLE) && ENABLE && any_pend;
    assign grant_clr = grant_now ? (N_REQ'(1) << winner) : '0;

    // A fresh edge on the line being granted re-arms it instead of counting as lost.
    always_comb begin
        pend_next = '0;
        drop_vec  = '0;
        n_drops   = '0;
        if (ENABLE) begin
            pend_next = (PENDING & ~grant_clr) | req_edge;
            drop_vec  = req_edge & PENDING & ~grant_clr;
        end
        for (int i = 0; i < N_REQ; i++) begin
            n_drops = n_drops + 5'(drop_vec[i]);
        end
        drop_sum  = {1'b0, DROP_COUNT} + 17'(n_drops);
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PENDING    <= '0;
            DROP_COUNT <= '0;
        end else begin
            PENDING <= pend_next;
            if (CLR_DROP) begin
                DROP_COUNT <= '0;
            end else begin
                DROP_COUNT <= drop_next;
            end
        end
    end

    // Hold-off is sampled once at acknowledge; later HOLDOFF changes wait for the next grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            TRIG_VALID <= 1'b0;
            TRIG_ID    <= '0;
            cnt        <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        TRIG_VALID <= 1'b1;
                        TRIG_ID    <= winner;
                        last_grant <= winner;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (TRIG_ACK) begin
                        TRIG_VALID <= 1'b0;
                        cnt        <= HOLDOFF;
                        state      <= (HOLDOFF == '0) ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= HOLDOFF_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    TRIG_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule
